// File: rtl/random_word_arbiter.sv
// Random word arbiter: packs debiased bits into words, buffers two of them
// and hands each one to exactly one requester in round-robin order.
module random_word_arbiter #(
    parameter int WIDTH        = 8,
    parameter int NUM_REQ      = 2,
    parameter int REPEAT_LIMIT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bit_valid,
    input  logic               bit_in,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [WIDTH-1:0]   word,
    output logic [1:0]         fill,
    output logic               health_fail
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] pend_word;
    logic             pend_valid;

    logic [7:0]       rep_cnt;
    logic [7:0]       rep_nxt;
    logic             prev_bit;

    logic [WIDTH-1:0] mem0;
    logic [WIDTH-1:0] mem1;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] sel_idx;
    logic             sel_found;

    logic             accept;
    logic             trip;
    logic             last_bit;
    logic             pop;
    logic             push;

    assign accept   = bit_valid && !health_fail;
    assign shifted  = {shreg[WIDTH-2:0], bit_in};
    assign last_bit = accept && (bit_cnt == CNT_W'(WIDTH - 1));

    // A zero count means no bit has been seen since reset.
    always_comb begin
        rep_nxt = 8'd1;
        if (rep_cnt != 8'd0 && bit_in == prev_bit) begin
            rep_nxt = (rep_cnt == 8'hFF) ? 8'hFF : rep_cnt + 8'd1;
        end
    end

    assign trip = accept && (int'(rep_nxt) >= REPEAT_LIMIT);

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!sel_found && req[(int'(rr_ptr) + k) % NUM_REQ]) begin
                sel_found = 1'b1;
                sel_idx   = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign pop  = sel_found && (fill != 2'd0) && !health_fail
                  && (grant == '0) && !trip;
    assign push = pend_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg       <= '0;
            bit_cnt     <= '0;
            pend_word   <= '0;
            pend_valid  <= 1'b0;
            rep_cnt     <= 8'd0;
            prev_bit    <= 1'b0;
            health_fail <= 1'b0;
        end else if (trip) begin
            shreg       <= '0;
            bit_cnt     <= '0;
            pend_valid  <= 1'b0;
            rep_cnt     <= rep_nxt;
            prev_bit    <= bit_in;
            health_fail <= 1'b1;
        end else begin
            pend_valid <= 1'b0;
            if (accept) begin
                rep_cnt  <= rep_nxt;
                prev_bit <= bit_in;
                if (last_bit) begin
                    pend_word  <= shifted;
                    pend_valid <= 1'b1;
                    shreg      <= '0;
                    bit_cnt    <= '0;
                end else begin
                    shreg   <= shifted;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Two-entry FIFO, mem0 is the head; a push into a full FIFO
    // only survives when the head leaves in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || trip) begin
            mem0 <= '0;
            mem1 <= '0;
            fill <= 2'd0;
        end else begin
            case ({push, pop})
                2'b01: begin
                    mem0 <= mem1;
                    fill <= fill - 2'd1;
                end
                2'b10: begin
                    if (fill == 2'd0) begin
                        mem0 <= pend_word;
                        fill <= 2'd1;
                    end else if (fill == 2'd1) begin
                        mem1 <= pend_word;
                        fill <= 2'd2;
                    end
                end
                2'b11: begin
                    if (fill == 2'd1) begin
                        mem0 <= pend_word;
                    end else begin
                        mem0 <= mem1;
                        mem1 <= pend_word;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant  <= '0;
            word   <= '0;
            rr_ptr <= '0;
        end else if (pop) begin
            grant  <= NUM_REQ'(1) << sel_idx;
            word   <= mem0;
            rr_ptr <= (sel_idx == PTR_W'(NUM_REQ - 1)) ? '0
                                                        : sel_idx + PTR_W'(1);
        end else begin
            grant <= '0;
            word  <= '0;
        end
    end

endmodule

// File: tb/tb_random_word_arbiter.sv
// Bench for random_word_arbiter: directed scenarios plus random traffic
// checked cycle by cycle against a queue-based model.
module tb_random_word_arbiter;

    localparam int W = 8;
    localparam int N = 2;
    localparam int L = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         bit_valid;
    logic         bit_in;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic [W-1:0] word;
    logic [1:0]   fill;
    logic         health_fail;

    int total = 0;
    int bad   = 0;

    int q[$];
    bit m_pend;
    int m_pend_w;
    int m_acc;
    int m_nbits;
    int m_run;
    bit m_last;
    bit m_hf;
    int m_gnt;
    int m_next;
    int m_word;

    random_word_arbiter #(.WIDTH(W), .NUM_REQ(N), .REPEAT_LIMIT(L)) dut (
        .clk(clk),
        .rst(rst),
        .bit_valid(bit_valid),
        .bit_in(bit_in),
        .req(req),
        .grant(grant),
        .word(word),
        .fill(fill),
        .health_fail(health_fail)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit v, input bit b,
                              input logic [N-1:0] rq);
        int  run;
        bit  trp;
        int  g;
        if (r) begin
            q.delete();
            m_pend = 0; m_acc = 0; m_nbits = 0; m_run = 0; m_last = 0;
            m_hf = 0; m_gnt = -1; m_next = 0; m_word = 0;
            return;
        end
        trp = 0;
        run = m_run;
        if (v && !m_hf) begin
            run = (m_run == 0 || b != m_last) ? 1 : m_run + 1;
            trp = (run >= L);
        end
        g = -1;
        if (q.size() > 0 && !m_hf && m_gnt < 0 && !trp)
            for (int k = 0; k < N; k++)
                if (g < 0 && rq[(m_next + k) % N]) g = (m_next + k) % N;
        if (trp) begin
            m_hf = 1; q.delete(); m_pend = 0; m_acc = 0; m_nbits = 0;
            m_gnt = -1; m_word = 0;
            return;
        end
        m_gnt  = g;
        m_word = 0;
        if (g >= 0) begin
            m_word = q.pop_front();
            m_next = (g + 1) % N;
        end
        if (m_pend && q.size() < 2) q.push_back(m_pend_w);
        m_pend = 0;
        if (v && !m_hf) begin
            m_run = run;
            m_last = b;
            m_acc = m_acc * 2 + int'(b);
            m_nbits++;
            if (m_nbits == W) begin
                m_pend = 1; m_pend_w = m_acc; m_acc = 0; m_nbits = 0;
            end
        end
    endtask

    task automatic tick(input bit r, input bit v, input bit b);
        int gexp;
        rst = r; bit_valid = v; bit_in = b;
        @(posedge clk);
        model_step(r, v, b, req);
        #1;
        gexp = (m_gnt < 0) ? 0 : (1 << m_gnt);
        chk("grant", 32'(grant), gexp);
        chk("word", 32'(word), m_word);
        chk("fill", 32'(fill), q.size());
        chk("health", 32'(health_fail), 32'(m_hf));
        if (m_gnt >= 0) req[m_gnt] = 1'b0;
    endtask

    task automatic feed_word(input logic [W-1:0] val);
        for (int i = W - 1; i >= 0; i--) tick(0, 1, val[i]);
    endtask

    task automatic raise_reqs(input int odds);
        for (int i = 0; i < N; i++)
            if (!req[i] && $urandom_range(odds - 1) == 0) req[i] = 1'b1;
    endtask

    initial begin
        bit b;
        rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; req = '0;

        // inputs during reset must be ignored
        req = '1;
        tick(1, 1, 1);
        tick(1, 1, 0);
        req = '0;
        chk("rst_fill", 32'(fill), 0);

        feed_word(8'hB2);
        tick(0, 0, 0);
        chk("b2_fill", 32'(fill), 1);
        req = 2'b01;
        tick(0, 0, 0);
        chk("b2_grant", 32'(grant), 1);
        chk("b2_word", 32'(word), 32'hB2);
        chk("b2_fill0", 32'(fill), 0);

        tick(1, 0, 0);
        feed_word(8'hA5);
        feed_word(8'h5A);
        feed_word(8'h3C);
        tick(0, 0, 0);
        tick(0, 0, 0);
        chk("full_fill", 32'(fill), 2);
        req = 2'b11;
        tick(0, 0, 0);
        chk("rr_g0", 32'(grant), 1);
        chk("rr_w0", 32'(word), 32'hA5);
        tick(0, 0, 0);
        chk("rr_idle", 32'(grant), 0);
        tick(0, 0, 0);
        chk("rr_g1", 32'(grant), 2);
        chk("rr_w1", 32'(word), 32'h5A);
        tick(0, 0, 0);
        chk("rr_empty", 32'(fill), 0);

        tick(1, 0, 0);
        feed_word(8'hAA);
        tick(0, 0, 0);
        chk("hf_pre", 32'(fill), 1);
        for (int i = 0; i < 16; i++) tick(0, 1, 1);
        chk("hf_set", 32'(health_fail), 1);
        chk("hf_fill", 32'(fill), 0);
        req = 2'b01;
        for (int i = 0; i < 20; i++) tick(0, 1, 1'($urandom_range(1)));
        chk("hf_nogrant", 32'(grant), 0);
        chk("hf_sticky", 32'(health_fail), 1);

        tick(1, 0, 0);
        req = '0;
        tick(0, 1, 1); tick(0, 1, 0); tick(0, 1, 1); tick(0, 1, 1);
        tick(0, 1, 0);
        tick(1, 0, 0);
        chk("mid_rst_fill", 32'(fill), 0);
        req = 2'b11;
        feed_word(8'hC3);
        tick(0, 0, 0);
        tick(0, 0, 0);
        chk("c3_grant", 32'(grant), 1);
        chk("c3_word", 32'(word), 32'hC3);

        tick(1, 0, 0);
        req = '0;
        for (int i = 0; i < 1000; i++) begin
            raise_reqs(3);
            tick(0, 1, 1'(i % 2));
        end
        chk("alt_hf", 32'(health_fail), 0);

        for (int seg = 0; seg < 4; seg++) begin
            tick(1, 0, 0);
            req = '0;
            b = 1'b0;
            for (int i = 0; i < 500; i++) begin
                raise_reqs(4);
                if ($urandom_range(3) != 0) begin
                    if ($urandom_range(9) < 5 + seg) b = ~b;
                    tick(0, 1, b);
                end else begin
                    tick(0, 0, 1'($urandom_range(1)));
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/random_word_arbiter.md
RANDOM_WORD_ARBITER -- requirements
Module: random_word_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: bits per delivered random word, legal range 2..32.
REQ-002 Parameter NUM_REQ, default 2: number of requesters, legal range 1..8.
REQ-003 Parameter REPEAT_LIMIT, default 16: run length of identical input bits that trips the health test, legal range 2..255.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 bit_valid  input  1  one-cycle strobe; bit_in is valid in this cycle.
REQ-007 bit_in  input  1  debiased random bit.
REQ-008 req  input  NUM_REQ  per-requester request level; held until granted.
REQ-009 grant  output  NUM_REQ  one-hot, one-cycle grant pulse.
REQ-010 word  output  WIDTH  random word; valid only in the cycle grant is nonzero.
REQ-011 fill  output  2  number of buffered words, 0..2.
REQ-012 health_fail  output  1  sticky repetition-test failure flag.

Function
REQ-013 Collector shall shift bit_in into a WIDTH-bit register on each bit_valid; first bit received ends in word MSB.
REQ-014 Collector shall complete a word on the WIDTH-th accepted bit and push it into a 2-entry FIFO in the following cycle.
REQ-015 If a word completes while fill==2 and no pop occurs that cycle, the new word shall be dropped and FIFO contents kept.
REQ-016 Push and pop in the same cycle with fill==2 shall both succeed; fill stays 2.
REQ-017 Arbiter shall consider requests only when fill>0, health_fail==0 and no grant was issued in the previous cycle.
REQ-018 Selection shall be round-robin: search starts at the index after the last granted requester; after reset, search starts at index 0.
REQ-019 Grant shall be registered: req sampled in cycle N yields grant and word in cycle N+1, with word taken from the FIFO head, which is popped.
REQ-020 Requester shall drop req in the cycle after its grant; an arbiter never grants in two consecutive cycles.
REQ-021 Each FIFO word shall be delivered to exactly one requester exactly once.
REQ-022 Repetition counter shall be 1 on the first bit after reset, increment (saturating) on each bit equal to the previous bit, and reload 1 on a differing bit.
REQ-023 When the counter reaches REPEAT_LIMIT, health_fail shall set in the next cycle, the partial word shall be discarded, the FIFO shall be flushed (fill=0), and no further grants shall be issued.
REQ-024 health_fail shall remain set until rst; bits continue to be ignored while it is set.
REQ-025 If health trips in the same cycle a word completes, the completed word shall be discarded.
REQ-026 fill shall reflect the FIFO state registered at the end of the previous cycle.

Reset
REQ-027 While rst is high: grant=0, word=0, fill=0, health_fail=0, collector bit count=0, repetition count=0, round-robin pointer=0.
REQ-028 rst asserted mid-word or mid-grant shall discard all partial and buffered data; the first grant after release requires a fresh WIDTH bits.
REQ-029 bit_valid and req shall be ignored in any cycle rst is high.

Verification
REQ-030 Defaults; feed bits 1,0,1,1,0,0,1,0 -> fill=1; req=01 -> next cycle grant=01, word=8'hB2, fill=0.
REQ-031 Fill FIFO with 8'hA5, 8'h5A; req=11 held, each requester drops req after its grant -> grant=01 with 8'hA5, idle cycle, grant=10 with 8'h5A.
REQ-032 Third word 8'h3C completes with fill==2 and no req -> fill stays 2; subsequent grants deliver only 8'hA5 then 8'h5A.
REQ-033 16 consecutive 1-bits with fill==1 -> health_fail=1 next cycle, fill=0; req=01 afterwards -> grant stays 0 until rst.
REQ-034 rst pulse after 5 bits of a word -> fill=0; 8 new bits 8'hC3 required before any grant; first grant after req=11 goes to requester 0.
REQ-035 Alternating bits 0,1 for 1000 cycles -> health_fail stays 0, every completed word 8'h55 delivered exactly once when requested.
